// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Purpose  : Round-robin burst arbiter sharing one FIFO push port among
//            NUM_REQ valid/ready producers; never pushes into a full FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_push,
    output logic [DATA_SIZE-1:0]           fifo_data,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    localparam logic [c_id_w-1:0]  c_reset_id = c_id_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_id_w-1:0]    r_last_id;
    logic [c_cnt_w-1:0]   r_burst_cnt;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [c_id_w-1:0]    w_last_id_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    logic                 w_win_found;
    logic [c_id_w-1:0]    w_win_id;
    logic [c_id_w-1:0]    w_idx;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic                 w_owner_valid;
    logic [DATA_SIZE-1:0] w_owner_data;
    logic                 w_xfer;

    // Search starts just after the previous winner so every producer rotates in.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_win_oh    = '0;
        w_idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = c_id_w'((int'(r_last_id) + k) % NUM_REQ);
            if (!w_win_found && req_valid[w_idx]) begin
                w_win_found      = 1'b1;
                w_win_id         = w_idx;
                w_win_oh         = '0;
                w_win_oh[w_idx]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_owner_data = req_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign busy          = (r_state == S_GRANT);
    assign grant         = r_grant;
    assign w_owner_valid = |(req_valid & r_grant);
    assign w_xfer        = busy && w_owner_valid && !fifo_full;
    assign fifo_push     = w_xfer;
    assign fifo_data     = w_xfer ? w_owner_data : '0;
    assign req_ready     = (busy && !fifo_full) ? r_grant : '0;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_id_nxt = r_last_id;
        w_cnt_nxt     = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt   = S_GRANT;
                    w_grant_nxt   = w_win_oh;
                    w_last_id_nxt = w_win_id;
                    w_cnt_nxt     = '0;
                end
            end
            S_GRANT: begin
                // A full FIFO with the owner still valid simply stalls.
                if (!w_owner_valid || (w_xfer && (r_burst_cnt == c_last_cnt))) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last_id   <= c_reset_id;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_last_id   <= w_last_id_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Purpose  : Scoreboard bench for fifo_push_arbiter (4 producers, 8-bit, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_push;
    logic [7:0]  fifo_data;
    logic [3:0]  grant;
    logic        busy;

    int          p_left [4];
    logic [7:0]  p_next [4];
    logic [7:0]  sb [$];
    int          n_cmp;
    int          n_bad;

    fifo_push_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]      = (p_left[i] > 0);
            req_data[i*8 +: 8] = p_next[i];
        end
    endtask

    // Producers advance on accepted words; every push is checked against the queue.
    task automatic tick();
        logic [7:0] exp_d;
        @(negedge clk);
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    p_next[i] = p_next[i] + 8'd1;
                    p_left[i] = p_left[i] - 1;
                end
            end
            if (fifo_push) begin
                n_cmp++;
                if (fifo_full) begin
                    n_bad++;
                    $display("FAIL push_into_full: fifo_push=1 with fifo_full=1, required no push");
                end else if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_push: data=%h, required no push", fifo_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (fifo_data !== exp_d) begin
                        n_bad++;
                        $display("FAIL push_data: got %h, expected %h", fifo_data, exp_d);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (sb.size() == 0 && !busy && p_left[0] == 0 && p_left[1] == 0 &&
                p_left[2] == 0 && p_left[3] == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p_left[i] = 1;
            p_next[i] = 8'hA0 + 8'(i);
            sb.push_back(8'hA0 + 8'(i));
        end
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0000 || fifo_push !== 1'b0 || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_hold: grant=%b push=%b ready=%b, required 0000/0/0000",
                         grant, fifo_push, req_ready);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_grant: grant=%b busy=%b, required 0001/1", grant, busy);
        end
        drain(ok);
        n_cmp++;
        if (!ok || sb.size() != 0) begin
            n_bad++;
            $display("FAIL reset_drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_single();
        bit ok;
        logic [3:0] g_tab [9] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                                  4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic       p_tab [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        p_left[2] = 6;
        p_next[2] = 8'h10;
        for (int k = 0; k < 6; k++) sb.push_back(8'h10 + 8'(k));
        drive();
        #1;
        for (int t = 0; t < 9; t++) begin
            tick();
            n_cmp++;
            if (grant !== g_tab[t] || fifo_push !== p_tab[t]) begin
                n_bad++;
                $display("FAIL single_cycle%0d: grant=%b push=%b, required %b/%b",
                         t + 1, grant, fifo_push, g_tab[t], p_tab[t]);
            end
            if (t == 0 || t == 5) begin
                n_cmp++;
                if (dut.r_last_id !== 2'd2) begin
                    n_bad++;
                    $display("FAIL single_last_id: got %0d, expected 2", dut.r_last_id);
                end
            end
        end
        drain(ok);
        n_cmp++;
        if (!ok || sb.size() != 0) begin
            n_bad++;
            $display("FAIL single_drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] exp_g;
        logic       exp_p;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p_left[i] = 8;
            p_next[i] = 8'h40 + 8'(i * 16);
        end
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++)
                sb.push_back(8'h40 + 8'((b % 4) * 16 + (b / 4) * 4 + k));
        drive();
        #1;
        for (int t = 0; t < 40; t++) begin
            tick();
            exp_g = ((t % 5) < 4) ? (4'b0001 << ((t / 5) % 4)) : 4'b0000;
            exp_p = ((t % 5) < 4);
            n_cmp++;
            if (grant !== exp_g || fifo_push !== exp_p) begin
                n_bad++;
                $display("FAIL rr_cycle%0d: grant=%b push=%b, required %b/%b",
                         t + 1, grant, fifo_push, exp_g, exp_p);
            end
        end
        drain(ok);
        n_cmp++;
        if (!ok || sb.size() != 0) begin
            n_bad++;
            $display("FAIL rr_drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_full_stall();
        bit ok;
        p_left[1] = 4;
        p_next[1] = 8'h60;
        for (int k = 0; k < 4; k++) sb.push_back(8'h60 + 8'(k));
        drive();
        #1;
        for (int t = 0; t < 2; t++) begin
            tick();
            n_cmp++;
            if (grant !== 4'b0010 || fifo_push !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_pre%0d: grant=%b push=%b, required 0010/1", t, grant, fifo_push);
            end
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            fifo_full = 1'b1;
            #1;
            n_cmp++;
            if (fifo_push !== 1'b0 || req_ready[1] !== 1'b0 || dut.r_burst_cnt !== 3'd2 ||
                grant !== 4'b0010) begin
                n_bad++;
                $display("FAIL stall_hold%0d: push=%b ready1=%b cnt=%0d grant=%b, required 0/0/2/0010",
                         t, fifo_push, req_ready[1], dut.r_burst_cnt, grant);
            end
        end
        tick();
        fifo_full = 1'b0;
        #1;
        n_cmp++;
        if (fifo_push !== 1'b1 || dut.r_burst_cnt !== 3'd2) begin
            n_bad++;
            $display("FAIL stall_resume: push=%b cnt=%0d, required 1/2", fifo_push, dut.r_burst_cnt);
        end
        tick();
        n_cmp++;
        if (fifo_push !== 1'b1 || dut.r_burst_cnt !== 3'd3) begin
            n_bad++;
            $display("FAIL stall_last: push=%b cnt=%0d, required 1/3", fifo_push, dut.r_burst_cnt);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL stall_end: busy=%b grant=%b, required 0/0000", busy, grant);
        end
        drain(ok);
        n_cmp++;
        if (!ok || sb.size() != 0) begin
            n_bad++;
            $display("FAIL stall_drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_early_drop();
        bit ok;
        p_left[3] = 1;
        p_next[3] = 8'h70;
        p_left[0] = 2;
        p_next[0] = 8'h80;
        sb.push_back(8'h70);
        sb.push_back(8'h80);
        sb.push_back(8'h81);
        drive();
        #1;
        tick();
        n_cmp++;
        if (grant !== 4'b1000 || fifo_push !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_grant3: grant=%b push=%b, required 1000/1", grant, fifo_push);
        end
        tick();
        n_cmp++;
        if (fifo_push !== 1'b0 || grant !== 4'b1000) begin
            n_bad++;
            $display("FAIL drop_invalid: push=%b grant=%b, required 0/1000", fifo_push, grant);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL drop_idle: busy=%b grant=%b, required 0/0000", busy, grant);
        end
        tick();
        n_cmp++;
        if (grant !== 4'b0001 || fifo_push !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_next0: grant=%b push=%b, required 0001/1", grant, fifo_push);
        end
        drain(ok);
        n_cmp++;
        if (!ok || sb.size() != 0) begin
            n_bad++;
            $display("FAIL drop_drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        p_left[2] = 6;
        p_next[2] = 8'h90;
        sb.push_back(8'h90);
        sb.push_back(8'h91);
        sb.push_back(8'hB0);
        sb.push_back(8'hB1);
        for (int k = 2; k < 6; k++) sb.push_back(8'h90 + 8'(k));
        drive();
        #1;
        for (int t = 0; t < 3; t++) tick();
        n_cmp++;
        if (fifo_push !== 1'b1 || fifo_data !== 8'h92) begin
            n_bad++;
            $display("FAIL rstmid_third: push=%b data=%h, required 1/92", fifo_push, fifo_data);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (fifo_push !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: push=%b grant=%b busy=%b, required 0/0000/0",
                     fifo_push, grant, busy);
        end
        p_left[1] = 2;
        p_next[1] = 8'hB0;
        tick();
        rst = 1'b0;
        #1;
        tick();
        n_cmp++;
        if (grant !== 4'b0010) begin
            n_bad++;
            $display("FAIL rstmid_regrant: grant=%b, required 0010", grant);
        end
        drain(ok);
        n_cmp++;
        if (!ok || sb.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_drain: %0d words outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < 4; i++) begin
            p_left[i] = 0;
            p_next[i] = 8'h00;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_drop();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write arbiter that shares the push port of one `fifo` instance among `NUM_REQ` producers. Each producer offers words over a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `MAX_BURST` words and drives the FIFO's `push`/`data_in` directly. It observes the FIFO's `full` flag, so it never issues a push into a full FIFO and the FIFO `overflow` flag never asserts from this source.

## Interface
- `NUM_REQ`, default 4: number of producers; at least 2.
- `DATA_SIZE`, default 8: word width; must match the FIFO `DATA_SIZE`.
- `MAX_BURST`, default 4: maximum words per grant; at least 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i set: producer i offers a word.
- `req_data`  in  NUM_REQ*DATA_SIZE  producer i's word in bits [i*DATA_SIZE +: DATA_SIZE].
- `req_ready`  out  NUM_REQ  bit i set: producer i's word is accepted this cycle.
- `fifo_full`  in  1  from FIFO `full`.
- `fifo_push`  out  1  to FIFO `push`.
- `fifo_data`  out  DATA_SIZE  to FIFO `data_in`.
- `grant`  out  NUM_REQ  one-hot current owner; all zeros when idle.
- `busy`  out  1  set in GRANT state.

## Operation
- FSM has two states, IDLE and GRANT. Registers:
  - `state`
  - `grant` (one-hot)
  - `last_id` (index of the last winner, width clog2(NUM_REQ))
  - `burst_cnt` (0..MAX_BURST)
- **IDLE:** if `req_valid` is nonzero, select the first set bit searching `last_id+1`, `last_id+2`, … modulo NUM_REQ. On the next edge:
  - `grant` becomes that one-hot value.
  - `last_id` takes the winner's index.
  - `burst_cnt` clears to 0.
  - `state` moves to GRANT.
  - If `req_valid` is zero, the FSM stays in IDLE.
- **GRANT** (owner g):
  - A transfer occurs when `req_valid[g]` and `!fifo_full`.
  - `fifo_push` equals the transfer condition; it is combinational.
  - `req_ready[g]` equals `!fifo_full`; all other `req_ready` bits are 0.
  - `fifo_data` equals `req_data` slice g. It is 0 whenever `fifo_push` is 0.
  - On a transfer, `burst_cnt` increments.
- **Burst end**, on the next edge, return to IDLE, clear `grant` and clear `burst_cnt` when either:
  - a transfer occurs with `burst_cnt == MAX_BURST-1`, or
  - `req_valid[g]` is 0, whether or not the FIFO is full.
- **Full stall:** `fifo_full` with `req_valid[g]` set holds GRANT. No transfer occurs and `burst_cnt` is unchanged. A stall never ends a burst.
- **Producer rules:**
  - While `req_valid` is set and `req_ready` is 0, hold `req_data` stable.
  - Deasserting `req_valid` mid-burst forfeits the rest of the grant.
  - Non-owner `req_valid` bits are ignored.
- **Fairness:** `last_id` updates only at grant. A producer that is continuously valid waits at most (NUM_REQ-1) bursts.

## Timing
- **Reset values:**
  - `state`=IDLE, `grant`=0, `busy`=0, `burst_cnt`=0.
  - `last_id`=NUM_REQ-1, so producer 0 has first priority.
  - `req_ready`=0, `fifo_push`=0, `fifo_data`=0.
- **Arbitration latency:** a request seen in IDLE at edge n gives `grant` and `busy` at n+1. The first push can occur in cycle n+1.
- **Throughput:** one word per cycle within a burst. One idle bubble cycle between bursts, so a 4-word burst occupies 5 cycles from the first grant to the next grant.
- `fifo_push`, `req_ready` and `fifo_data` are combinational from registered state plus `req_valid` and `fifo_full`. There is no added latency to the FIFO.
- **Asynchronous reset mid-burst:** the FSM returns to IDLE immediately and `fifo_push` drops in the same cycle, without waiting for an edge. A word whose push edge coincides with reset assertion is not considered written.
- **Simultaneous full and last transfer:** `fifo_full` takes priority. No transfer occurs and the burst continues.

## Test plan
Parameters for all scenarios: NUM_REQ=4, MAX_BURST=4, DATA_SIZE=8.

1. **Reset.** Hold `rst`=1 for 2 cycles with `req_valid`=4'b1111. Required: `grant`=0, `fifo_push`=0, `req_ready`=0 throughout. Release reset; the next edge gives `grant`=4'b0001.
2. **Single producer.** `req_valid`=4'b0100 with data 0x10..0x15 over 6 words, FIFO never full. Required:
   - `grant`=4'b0100 for 4 cycles, pushing 0x10..0x13.
   - One IDLE cycle.
   - Regrant, then push 0x14 and 0x15.
   - `last_id`=2 after each grant.
3. **Round robin.** All four producers continuously valid. Required:
   - Grant order 0, 1, 2, 3, 0.
   - Each burst is exactly 4 pushes.
   - Bursts are separated by exactly 1 idle cycle.
4. **Full stall.** Producer 1 granted; assert `fifo_full` for 3 cycles after its 2nd word. Required:
   - `fifo_push`=0 and `req_ready[1]`=0 during the stall.
   - `burst_cnt` stays at 2.
   - After `fifo_full` drops, exactly 2 more words are pushed, then IDLE.
5. **Early drop.** Producer 3 drops `req_valid` after 1 word. Required: IDLE on the next edge, then producer 0 is granted if it is valid.
6. **Reset mid-burst.** Assert `rst` asynchronously between edges during producer 2's 3rd word. Required:
   - `fifo_push` and `grant` go to 0 immediately.
   - After release, the first grant goes to the lowest-index valid producer.
